// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: loader state encoding
// and the MIPS NOP word used by fetch paths when no valid instruction exists.
package imem_loader_pkg;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } ld_state_e;

  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

endpackage

// File: rtl/imem_ram.sv
// Instruction storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the loader.
module imem_ram
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_loader.sv
// Instruction memory with a streaming image loader; holds the core in reset
// until a complete image is present and supports run-time reload.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] NOP_WORD = MIPS_NOP
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [31:0]     inst_addr_i,
  output logic [31:0]     inst_o,
  input  logic            ld_valid_i,
  output logic            ld_ready_o,
  input  logic [31:0]     ld_data_i,
  input  logic            ld_last_i,
  input  logic            reload_i,
  output logic            core_nrst_o,
  output logic            load_done_o,
  output logic [ADDR_W:0] ld_count_o,
  output logic            err_ovf_o
);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   ld_count_q, ld_count_d;
  logic              core_nrst_q, core_nrst_d;
  logic              err_ovf_q, err_ovf_d;
  logic              accept;

  logic [ADDR_W-1:0] rd_idx;
  logic [31:0]       ram_rdata;
  logic              rd_hit;
  logic              unused_byte_sel;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    ld_count_d  = ld_count_q;
    err_ovf_d   = err_ovf_q;
    core_nrst_d = 1'b0;
    accept      = 1'b0;
    ld_ready_o  = 1'b0;
    load_done_o = 1'b0;
    case (state_q)
      ST_LOAD: begin
        ld_ready_o = 1'b1;
        accept     = ld_valid_i;
        if (accept) begin
          wr_ptr_d   = wr_ptr_q + 1'b1;
          ld_count_d = ld_count_q + 1'b1;
          // Filling the last slot ends the load even without ld_last (truncated image).
          if (ld_last_i || (wr_ptr_q == '1)) begin
            state_d = ST_RUN;
            if (!ld_last_i) err_ovf_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        load_done_o = 1'b1;
        core_nrst_d = 1'b1;
        if (reload_i) begin
          state_d     = ST_LOAD;
          wr_ptr_d    = '0;
          ld_count_d  = '0;
          core_nrst_d = 1'b0;
        end
      end
    endcase
  end

  // core_nrst_d is derived from the current state, so release lags RUN entry by one clock.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_LOAD;
      wr_ptr_q    <= '0;
      ld_count_q  <= '0;
      core_nrst_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      ld_count_q  <= ld_count_d;
      core_nrst_q <= core_nrst_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  imem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (wr_ptr_q),
    .wdata_i (ld_data_i),
    .raddr_i (rd_idx),
    .rdata_o (ram_rdata)
  );

  assign rd_idx          = inst_addr_i[ADDR_W+1:2];
  assign unused_byte_sel = ^inst_addr_i[1:0];
  assign rd_hit          = (state_q == ST_RUN) &&
                           (inst_addr_i[31:ADDR_W+2] == '0) &&
                           ({1'b0, rd_idx} < ld_count_q);
  assign inst_o          = rd_hit ? ram_rdata : NOP_WORD;

  assign core_nrst_o = core_nrst_q;
  assign ld_count_o  = ld_count_q;
  assign err_ovf_o   = err_ovf_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (ADDR_W=10 and ADDR_W=3) driven with
// directed sequences and random data, checked against an image-level model.
module tb_imem_loader;

  logic        clk;
  logic        nrst;
  logic        vld [2];
  logic        lst [2];
  logic        rld [2];
  logic [31:0] dat [2];
  logic [31:0] adr [2];

  logic [31:0] inst_a, inst_b;
  logic        rdy_a, rdy_b, core_a, core_b, done_a, done_b, err_a, err_b;
  logic [10:0] cnt_a;
  logic [3:0]  cnt_b;

  // Reference model: the image as a list of words plus run/core/overflow flags
  logic [31:0] mimg [2][1024];
  int          mcnt [2];
  bit          mrun [2];
  bit          mcore[2];
  bit          merr [2];

  int errs;
  int checks;

  imem_loader #(.ADDR_W(10)) u_dut_a (
    .clk(clk), .nrst(nrst), .inst_addr_i(adr[0]), .inst_o(inst_a),
    .ld_valid_i(vld[0]), .ld_ready_o(rdy_a), .ld_data_i(dat[0]), .ld_last_i(lst[0]),
    .reload_i(rld[0]), .core_nrst_o(core_a), .load_done_o(done_a),
    .ld_count_o(cnt_a), .err_ovf_o(err_a)
  );

  imem_loader #(.ADDR_W(3)) u_dut_b (
    .clk(clk), .nrst(nrst), .inst_addr_i(adr[1]), .inst_o(inst_b),
    .ld_valid_i(vld[1]), .ld_ready_o(rdy_b), .ld_data_i(dat[1]), .ld_last_i(lst[1]),
    .reload_i(rld[1]), .core_nrst_o(core_b), .load_done_o(done_b),
    .ld_count_o(cnt_b), .err_ovf_o(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int aw(int d);
    return (d == 0) ? 10 : 3;
  endfunction

  function automatic int depth(int d);
    return 1 << aw(d);
  endfunction

  function automatic logic [31:0] exp_inst(int d, logic [31:0] a);
    int idx;
    if (!mrun[d]) return 32'h0;
    if ((a >> (aw(d) + 2)) != 0) return 32'h0;
    idx = int'(a >> 2);
    if (idx >= mcnt[d]) return 32'h0;
    return mimg[d][idx];
  endfunction

  function automatic logic [31:0] exp_status(int d);
    logic [11:0] c;
    c = 12'(mcnt[d]);
    return {16'h0, merr[d], mcore[d], mrun[d], !mrun[d], c};
  endfunction

  function automatic logic [31:0] obs_status(int d);
    if (d == 0) return {16'h0, err_a, core_a, done_a, rdy_a, 1'b0, cnt_a};
    return {16'h0, err_b, core_b, done_b, rdy_b, 8'h0, cnt_b};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mcnt[d] = 0; mrun[d] = 0; mcore[d] = 0; merr[d] = 0;
    end
  endtask

  // One clock edge: update the model from the inputs that were stable across it.
  task automatic tick();
    bit nc;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      nc = mrun[d] && !rld[d];
      if (vld[d] && !mrun[d]) begin
        mimg[d][mcnt[d]] = dat[d];
        mcnt[d]++;
        if (lst[d] || mcnt[d] == depth(d)) begin
          mrun[d] = 1;
          if (!lst[d]) merr[d] = 1;
        end
      end else if (mrun[d] && rld[d]) begin
        mrun[d] = 0;
        mcnt[d] = 0;
      end
      mcore[d] = nc;
    end
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(int d, string tag);
    chk(tag, obs_status(d), exp_status(d));
  endtask

  task automatic chk_inst(int d, logic [31:0] a, string tag);
    adr[d] = a;
    tick();
    chk(tag, (d == 0) ? inst_a : inst_b, exp_inst(d, a));
  endtask

  task automatic beat(int d, logic v, logic [31:0] w, logic l);
    vld[d] = v; dat[d] = w; lst[d] = l;
    tick();
    vld[d] = 1'b0; lst[d] = 1'b0; dat[d] = $urandom;
  endtask

  task automatic do_reload(int d);
    rld[d] = 1'b1;
    tick();
    rld[d] = 1'b0;
  endtask

  initial begin
    logic [31:0] prog [4];
    errs = 0; checks = 0;
    prog[0] = 32'h20080005; prog[1] = 32'h20090003;
    prog[2] = 32'h01095020; prog[3] = 32'hAC0A0000;
    nrst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      vld[d] = 0; lst[d] = 0; rld[d] = 0; dat[d] = 0; adr[d] = 0;
    end
    model_reset();
    #3;
    chk_status(0, "reset_a");
    chk_status(1, "reset_b");
    #10 nrst = 1'b1;
    tick();
    chk_status(0, "post_reset_a");

    // Directed 4-word program with ld_last on the final word
    for (int i = 0; i < 4; i++) begin
      beat(0, 1'b1, prog[i], i == 3);
      chk_status(0, "t1_load");
    end
    tick();
    chk_status(0, "t1_core_rise");
    chk_inst(0, 32'h8, "t1_rd_08");
    chk(  "t1_rd_08_lit", inst_a, 32'h01095020);
    chk_inst(0, 32'h10, "t1_rd_10");

    // Throttled load with idle gap and an ignored reload while loading
    do_reload(0);
    chk_status(0, "t2_reload");
    for (int i = 0; i < 6; i++) begin
      beat(0, 1'b1, $urandom, i == 5);
      chk_status(0, "t2_beat");
      if (i == 1) rld[0] = 1'b1;
      beat(0, 1'b0, $urandom, 1'b1);
      rld[0] = 1'b0;
      chk_status(0, "t2_gap");
      if (i == 2) for (int k = 0; k < 3; k++) begin
        beat(0, 1'b0, $urandom, 1'b0);
        chk_status(0, "t2_idle");
      end
    end
    for (int i = 0; i < 7; i++) chk_inst(0, 32'(i * 4), "t2_readback");

    // Overflow on the small instance: 10 words offered, 8 fit
    for (int i = 0; i < 10; i++) begin
      beat(1, 1'b1, $urandom, 1'b0);
      chk_status(1, "t3_stream");
    end
    chk_inst(1, 32'h1C, "t3_rd_1c");
    chk_inst(1, 32'h20, "t3_rd_20");
    chk_status(1, "t3_err");

    // Reload at run time with a 2-word image
    adr[0] = 32'h8;
    do_reload(0);
    chk_status(0, "t4_core_fall");
    chk(  "t4_nop_reload", inst_a, exp_inst(0, 32'h8));
    beat(0, 1'b1, $urandom, 1'b0);
    chk(  "t4_nop_loading", inst_a, exp_inst(0, 32'h8));
    beat(0, 1'b1, $urandom, 1'b1);
    chk_status(0, "t4_run");
    chk_inst(0, 32'h8, "t4_stale_08");
    chk_inst(0, 32'h4, "t4_rd_04");

    // Asynchronous reset partway through a 6-word image
    do_reload(0);
    for (int i = 0; i < 3; i++) beat(0, 1'b1, $urandom, 1'b0);
    nrst = 1'b0;
    #1;
    model_reset();
    chk_status(0, "t5_async_a");
    chk_status(1, "t5_async_b");
    chk(  "t5_inst_nop", inst_a, 32'h0);
    #2 nrst = 1'b1;
    for (int i = 0; i < 6; i++) beat(0, 1'b1, $urandom, i == 5);
    chk_status(0, "t5_reloaded");
    for (int i = 0; i < 7; i++) chk_inst(0, 32'(i * 4), "t5_readback");

    // Out-of-range and unaligned fetches, then a random address sweep
    chk_inst(0, 32'h0000_1000, "t6_oor");
    chk_inst(0, 32'h0000_0006, "t6_unaligned");
    for (int i = 0; i < 16; i++) chk_inst(0, $urandom_range(0, 32'h1FFF), "t6_sweep");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
